card_reader: RTL and testbench
==============================

# card_reader

Sequential card reader that sits directly downstream of the punch-card ROM. On `start` it selects one equation card, steps the row address, and reads one 20-bit row per cycle. Each row carries one decimal digit per field, most significant row first. The block converts the four fields (x, y, z coefficients and constant b) from decimal to binary by accumulating `acc*10 + digit`. It presents the four binary values to the downstream solver with a one-cycle `done` pulse.

## Interface
- `CARD_ROWS`, 15: rows per card; the last readable address is CARD_ROWS-1.
- `ACC_W`, 50: width of each binary accumulator. Must be ≥ 50 so that 15 decimal digits cannot overflow.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `start`  in  1  begin a read. Sampled only in IDLE.
- `card_sel`  in  2  equation card to read. Values 1..3 are valid; 0 is illegal.
- `card_slt`  out  2  card select to the ROM, latched from `card_sel` at start.
- `mask`  out  1  ROM mask select; tied 0 (equation cards only).
- `card_addr`  out  4  ROM row address.
- `card_in`  in  20  ROM row data, combinational from `card_slt`/`card_addr`.
- `busy`  out  1  high in READ.
- `done`  out  1  one-cycle pulse when a conversion completes.
- `err`  out  1  valid with `done`; held until the next `done`.
- `coef_x`, `coef_y`, `coef_z`, `coef_b`  out  ACC_W each  converted values.

## Operation
- **Row format:**
  - `[19:16]` = x, `[15:12]` = y, `[11:8]` = z, `[7:4]` = b.
  - `[3:0]` is reserved and ignored.
- **Nibble meaning:**
  - 0..9: digit.
  - F: the field has ended.
  - A..E: illegal.
- **FSM states:** IDLE, READ, FINISH.
- **IDLE:**
  - `card_addr` = 0 and `busy` = 0.
  - When `start` = 1 and `card_sel` ≠ 0:
    - latch `card_slt`;
    - clear the four accumulators;
    - mark all four fields active;
    - clear the internal error flag;
    - go to READ.
  - When `start` = 1 and `card_sel` = 0:
    - set the error flag;
    - clear the accumulators;
    - go to FINISH.
- **READ, one row per cycle,** for each active field:
  - digit 0..9: `acc = acc*10 + digit`.
  - F: the field becomes inactive; the accumulator is unchanged.
  - A..E: the field becomes inactive and the error flag is set.
  - Inactive fields ignore later rows, even if those rows contain digits.
- **Leaving READ:**
  - The block goes to FINISH after processing a row if all fields are then inactive, or if `card_addr` = CARD_ROWS-1.
  - Otherwise it increments `card_addr`.
- **On entering FINISH:**
  - copy the accumulators to the `coef_*` outputs;
  - copy the error flag to `err`.
- **FINISH:** `done` = 1 for exactly one cycle, then the FSM returns to IDLE and `card_addr` returns to 0.
- **Output hold:** `coef_*` and `err` are stable between `done` pulses.
- **Start handling:** `start` during READ or FINISH is ignored; it is not queued.

## Timing
- **Reset values:**
  - state IDLE;
  - `card_addr` = 0, `card_slt` = 0, `mask` = 0;
  - `busy` = 0, `done` = 0, `err` = 0;
  - all `coef_*` = 0.
- **Reset mid-run:** forces the reset values on the next edge. No `done` pulse is issued and no outputs are updated.
- **Read path:** `card_in` is sampled on the same edge that `card_addr` addresses it; there is no ROM wait state.
- **Latency:** a card whose terminating row is at address N produces `done` in the cycle after edge N+2, counting `start` as sampled at edge 0.
  - Example: digits in row 0 and an all-F row at address 1 give `done` after edge 3.
- **Maximum latency:** a full card with no terminating row produces `done` after edge CARD_ROWS+1.
- **`busy` window:** high from edge 0 through the edge that processes the last row.
- **Illegal select:** with `card_sel` = 0, `done` (with `err` = 1) follows edge 1.

## Test plan
- **Reset:** `rst` for 2 cycles → all outputs 0 and `card_addr` = 0.
- **Single-digit card 1:** rows 0x2535F then 0xFFFFF → `coef_x/y/z/b` = 2/5/3/5, `err` = 0, `done` high for exactly one cycle after edge 3, `card_addr` back to 0.
- **Multi-digit, bench-driven rows:** rows 0x1234F, 0x0567F, 0x8F9FF, 0xFFFFF → x = 108, y = 25, z = 369, b = 47.
  - Verifies that a field ending early ignores later rows.
- **Full card:** 15 rows of 0x9999F → each coef = 10^15 − 1, `done` after edge 16, no overflow.
- **Illegal input:**
  - a row containing nibble A in y → y holds its prior value, `err` = 1;
  - `card_sel` = 0 → `err` = 1, coefs = 0, `done` after edge 1.
- **Control corners:**
  - `start` pulsed while busy → ignored, one `done` only;
  - `rst` asserted mid-READ → no `done`, outputs cleared;
  - a new `start` the cycle after `done` → works normally.

Source files
------------

// File: rtl/card_reader.sv
// card_reader: reads one equation card from the punch-card ROM, row by row,
// and converts the four decimal fields (x, y, z, b) to binary.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a read (sampled in IDLE only)
//   card_sel       card to read, 1..3 valid, 0 illegal
//   card_slt       latched card select to the ROM
//   mask           ROM mask select, always 0
//   card_addr      ROM row address
//   card_in        ROM row data, combinational from card_slt/card_addr
//   busy           high while rows are being read
//   done           one-cycle completion pulse
//   err            error status, valid with done, held until next done
//   coef_x/y/z/b   converted binary values, held until next done
module card_reader #(
    parameter int CARD_ROWS = 15,
    parameter int ACC_W     = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       card_sel,
    output logic [1:0]       card_slt,
    output logic             mask,
    output logic [3:0]       card_addr,
    input  logic [19:0]      card_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ACC_W-1:0] coef_x,
    output logic [ACC_W-1:0] coef_y,
    output logic [ACC_W-1:0] coef_z,
    output logic [ACC_W-1:0] coef_b
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FINISH
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(CARD_ROWS - 1);

    state_t state, state_n;

    // Field index 0..3 = x, y, z, b; field i sits at card_in[16-4*i +: 4].
    logic [3:0][ACC_W-1:0] acc, acc_n;
    logic [3:0]            act, act_n;
    logic                  errf, errf_n;
    logic [3:0]            nib;

    assign mask = 1'b0;
    assign busy = (state == READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        act_n   = act;
        errf_n  = errf;
        nib     = 4'h0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_n = '0;
                    if (card_sel != 2'd0) begin
                        act_n   = 4'hF;
                        errf_n  = 1'b0;
                        state_n = READ;
                    end else begin
                        act_n   = 4'h0;
                        errf_n  = 1'b1;
                        state_n = FINISH;
                    end
                end
            end
            READ: begin
                for (int i = 0; i < 4; i++) begin
                    nib = card_in[16-4*i +: 4];
                    if (act[i]) begin
                        if (nib <= 4'd9) begin
                            // acc*10 as (acc<<3)+(acc<<1)
                            acc_n[i] = (acc[i] << 3) + (acc[i] << 1)
                                     + ACC_W'(nib);
                        end else begin
                            act_n[i] = 1'b0;
                            if (nib != 4'hF) begin
                                errf_n = 1'b1;
                            end
                        end
                    end
                end
                if (act_n == 4'h0 || card_addr == LAST_ADDR) begin
                    state_n = FINISH;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            act       <= '0;
            errf      <= 1'b0;
            card_addr <= 4'd0;
            card_slt  <= 2'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            coef_x    <= '0;
            coef_y    <= '0;
            coef_z    <= '0;
            coef_b    <= '0;
        end else begin
            acc  <= acc_n;
            act  <= act_n;
            errf <= errf_n;
            done <= (state == FINISH);
            if (state == IDLE && start && card_sel != 2'd0) begin
                card_slt <= card_sel;
            end
            if (state == READ && state_n == READ) begin
                card_addr <= card_addr + 4'd1;
            end else if (state == FINISH) begin
                card_addr <= 4'd0;
            end
            // Results are captured on the edge that enters FINISH, so the
            // final row's contribution comes from the next-state values.
            if (state != FINISH && state_n == FINISH) begin
                coef_x <= acc_n[0];
                coef_y <= acc_n[1];
                coef_z <= acc_n[2];
                coef_b <= acc_n[3];
                err    <= errf_n;
            end
        end
    end

endmodule

// File: tb/tb_card_reader.sv
// tb_card_reader: directed self-checking bench for card_reader.
// The ROM is modelled as a bench array indexed by card_slt/card_addr.
module tb_card_reader;

    localparam int ACC_W = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       card_sel;
    logic [1:0]       card_slt;
    logic             mask;
    logic [3:0]       card_addr;
    logic [19:0]      card_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [ACC_W-1:0] coef_x, coef_y, coef_z, coef_b;

    logic [19:0] rom [4][16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign card_in = rom[card_slt][card_addr];

    card_reader #(.CARD_ROWS(15), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .card_sel  (card_sel),
        .card_slt  (card_slt),
        .mask      (mask),
        .card_addr (card_addr),
        .card_in   (card_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .coef_x    (coef_x),
        .coef_y    (coef_y),
        .coef_z    (coef_z),
        .coef_b    (coef_b)
    );

    task automatic fill(input int c, input logic [19:0] v);
        for (int a = 0; a < 16; a++) rom[c][a] = v;
    endtask

    // Start a read at edge 0, then watch maxe edges for done.
    task automatic run(input logic [1:0] sel, input int maxe,
                       output int dedge, output int ndone);
        start = 1'b1;
        card_sel = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        dedge = -1;
        ndone = 0;
        for (int e = 1; e <= maxe; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (dedge < 0) dedge = e;
            end
        end
    endtask

    task automatic check_coefs(input string nm,
                               input logic [ACC_W-1:0] x, y, z, b,
                               input logic e);
        checks++;
        if ({coef_x, coef_y, coef_z, coef_b, err} !== {x, y, z, b, e}) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d z=%0d b=%0d err=%0b, want x=%0d y=%0d z=%0d b=%0d err=%0b",
                     nm, coef_x, coef_y, coef_z, coef_b, err, x, y, z, b, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        card_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, err, mask, card_slt, card_addr} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%0b done=%0b err=%0b mask=%0b slt=%0d addr=%0d, want all 0",
                     busy, done, err, mask, card_slt, card_addr);
        end
        check_coefs("reset_coefs", 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_single_digit();
        int de, nd;
        rom[1][0] = 20'h2535F;
        rom[1][1] = 20'hFFFFF;
        run(2'd1, 10, de, nd);
        checks++;
        if (de !== 3 || nd !== 1) begin
            errors++;
            $display("FAIL single_done: got edge=%0d count=%0d, want edge=3 count=1", de, nd);
        end
        check_coefs("single_vals", 2, 5, 3, 5, 1'b0);
        checks++;
        if (card_addr !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got addr=%0d busy=%0b, want 0 0", card_addr, busy);
        end
    endtask

    task automatic test_multi_digit();
        int de, nd;
        fill(2, 20'hFFFFF);
        rom[2][0] = 20'h1234F;
        rom[2][1] = 20'h0567F;
        rom[2][2] = 20'h8F9FF;
        rom[2][3] = 20'hFFFFF;
        run(2'd2, 10, de, nd);
        checks++;
        if (de !== 5 || nd !== 1) begin
            errors++;
            $display("FAIL multi_done: got edge=%0d count=%0d, want edge=5 count=1", de, nd);
        end
        check_coefs("multi_vals", 108, 25, 369, 47, 1'b0);
        checks++;
        if (card_slt !== 2'd2) begin
            errors++;
            $display("FAIL multi_slt: got %0d, want 2", card_slt);
        end
    endtask

    task automatic test_full_card();
        int de, nd;
        logic [ACC_W-1:0] m;
        m = 50'd999_999_999_999_999;
        fill(3, 20'h9999F);
        run(2'd3, 20, de, nd);
        checks++;
        if (de !== 16 || nd !== 1) begin
            errors++;
            $display("FAIL full_done: got edge=%0d count=%0d, want edge=16 count=1", de, nd);
        end
        check_coefs("full_vals", m, m, m, m, 1'b0);
    endtask

    task automatic test_illegal_nibble();
        int de, nd;
        fill(1, 20'hFFFFF);
        rom[1][0] = 20'h1234F;
        rom[1][1] = 20'h5A67F;
        rom[1][2] = 20'hFFFFF;
        run(2'd1, 10, de, nd);
        checks++;
        if (de !== 4 || nd !== 1) begin
            errors++;
            $display("FAIL badnib_done: got edge=%0d count=%0d, want edge=4 count=1", de, nd);
        end
        check_coefs("badnib_vals", 15, 2, 36, 47, 1'b1);
    endtask

    task automatic test_illegal_sel();
        int de, nd;
        run(2'd0, 5, de, nd);
        checks++;
        if (de !== 1 || nd !== 1) begin
            errors++;
            $display("FAIL badsel_done: got edge=%0d count=%0d, want edge=1 count=1", de, nd);
        end
        check_coefs("badsel_vals", 0, 0, 0, 0, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int de, nd;
        start = 1'b1;
        card_sel = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        de = -1;
        nd = 0;
        for (int e = 1; e <= 25; e++) begin
            start = (e == 3 || e == 15);
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (de < 0) de = e;
            end
        end
        start = 1'b0;
        checks++;
        if (de !== 16 || nd !== 1) begin
            errors++;
            $display("FAIL busy_start: got edge=%0d count=%0d, want edge=16 count=1", de, nd);
        end
    endtask

    task automatic test_reset_mid_read();
        int nd;
        run(2'd3, 5, nd, nd);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, card_addr, card_slt} !== 8'd0) begin
            errors++;
            $display("FAIL midrst_ctrl: got busy=%0b done=%0b addr=%0d slt=%0d, want all 0",
                     busy, done, card_addr, card_slt);
        end
        check_coefs("midrst_vals", 0, 0, 0, 0, 1'b0);
        nd = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL midrst_nodone: got %0d done pulses, want 0", nd);
        end
    endtask

    task automatic test_back_to_back();
        int de, nd;
        fill(1, 20'hFFFFF);
        rom[1][0] = 20'h2535F;
        run(2'd1, 3, de, nd);
        checks++;
        if (de !== 3 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got edge=%0d done=%0b, want edge=3 done=1", de, done);
        end
        run(2'd2, 10, de, nd);
        checks++;
        if (de !== 5 || nd !== 1) begin
            errors++;
            $display("FAIL b2b_second: got edge=%0d count=%0d, want edge=5 count=1", de, nd);
        end
        check_coefs("b2b_vals", 108, 25, 369, 47, 1'b0);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) fill(c, 20'hFFFFF);
        test_reset();
        test_single_digit();
        test_multi_digit();
        test_full_card();
        test_illegal_nibble();
        test_illegal_sel();
        test_start_while_busy();
        test_reset_mid_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
